// File: rtl/counter_rd_arbiter.sv
// Round-robin read arbiter in front of the shared counter readout mux.
// Grants one requester at a time while the link is idle and returns the count with a one-hot ack.
module counter_rd_arbiter #(
    parameter int N_REQ = 3,
    parameter int N_CNT = 5
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic [3:0]         state,
    input  logic [N_REQ-1:0]   rd_req,
    input  logic [3*N_REQ-1:0] rd_idx,
    input  logic [7:0]         mux_data,
    input  logic               mux_valid,
    output logic               mux_req,
    output logic [2:0]         mux_idx,
    output logic [N_REQ-1:0]   rd_ack,
    output logic [7:0]         rd_data,
    output logic               rd_err,
    output logic               busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] ST_IDLE = 4'b0100;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic             abort_q, abort_d;
    logic             mux_req_q, mux_req_d;
    logic [2:0]       mux_idx_q, mux_idx_d;
    logic [N_REQ-1:0] rd_ack_q, rd_ack_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_err_q, rd_err_d;

    logic [N_REQ-1:0] eligible;
    logic             win_vld;
    logic [PW-1:0]    win;
    logic [PW-1:0]    cand;
    logic [2:0]       win_idx;
    logic             win_oor;
    int               sum;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
        logic [PW-1:0] r;
        if (int'(g) >= N_REQ - 1) r = '0;
        else                      r = g + PW'(1);
        return r;
    endfunction

    // Scan from the pointer downward in reverse so the closest eligible requester wins last.
    always_comb begin
        eligible = rd_req & ~rd_ack_q;
        win_vld  = 1'b0;
        win      = '0;
        cand     = '0;
        sum      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = int'(ptr_q) + k;
            if (sum >= N_REQ) sum = sum - N_REQ;
            cand = sum[PW-1:0];
            if (eligible[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
        win_idx = rd_idx[3*int'(win) +: 3];
        win_oor = (int'(win_idx) >= N_CNT);
    end

    always_comb begin
        fsm_d     = fsm_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        abort_d   = abort_q;
        mux_req_d = 1'b0;
        mux_idx_d = mux_idx_q;
        rd_ack_d  = '0;
        rd_err_d  = 1'b0;
        rd_data_d = rd_data_q;
        case (fsm_q)
            ARB: begin
                if (state == ST_IDLE && win_vld) begin
                    if (win_oor) begin
                        // Bad index is answered locally; the mux never sees it.
                        rd_ack_d[win] = 1'b1;
                        rd_err_d      = 1'b1;
                        rd_data_d     = 8'h00;
                        ptr_d         = next_ptr(win);
                    end else begin
                        gnt_d     = win;
                        mux_idx_d = win_idx;
                        mux_req_d = 1'b1;
                        abort_d   = 1'b0;
                        fsm_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                fsm_d = WAIT;
                if (state != ST_IDLE) abort_d = 1'b1;
            end
            WAIT: begin
                // Leaving idle at any point of the read drops it; the requester is re-arbitrated.
                if (mux_valid && !abort_q && state == ST_IDLE) begin
                    rd_data_d       = mux_data;
                    rd_ack_d[gnt_q] = 1'b1;
                    ptr_d           = next_ptr(gnt_q);
                end
                abort_d = 1'b0;
                fsm_d   = ARB;
            end
            default: begin
                fsm_d   = ARB;
                abort_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fsm_q     <= ARB;
            ptr_q     <= '0;
            gnt_q     <= '0;
            abort_q   <= 1'b0;
            mux_req_q <= 1'b0;
            mux_idx_q <= 3'd0;
            rd_ack_q  <= '0;
            rd_data_q <= 8'h00;
            rd_err_q  <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            abort_q   <= abort_d;
            mux_req_q <= mux_req_d;
            mux_idx_q <= mux_idx_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign mux_req = mux_req_q;
    assign mux_idx = mux_idx_q;
    assign rd_ack  = rd_ack_q;
    assign rd_data = rd_data_q;
    assign rd_err  = rd_err_q;
    assign busy    = (fsm_q != ARB);

endmodule
